rpn_exec_sequencer: RTL



---
 rtl/rpn_exec_sequencer_pkg.sv | 28 ++
 rtl/rpn_exec_sequencer_if.sv | 25 ++
 rtl/rpn_exec_sequencer_alu.sv | 28 ++
 rtl/rpn_exec_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rpn_exec_sequencer_pkg.sv
// Shared definitions for the RPN calculator execution path:
// opcodes, error codes and the sequencer state encoding.
package calc_pkg;

  localparam logic [2:0] OP_LIT  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP_A   = 3'd1,
    POP_B   = 3'd2,
    RESTORE = 3'd3,
    EXEC    = 3'd4,
    PUSH    = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/rpn_exec_sequencer_if.sv
// Command/response channel between the front-end controller (master)
// and the execution sequencer (slave).
interface rpn_exec_sequencer_if #(
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_mode;
  logic [DW-1:0] result;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_mode,
    input  cmd_ready, result, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_mode,
    output cmd_ready, result, done, err, err_code
  );
endinterface

// File: rtl/rpn_exec_sequencer_alu.sv
// Combinational 32-bit calculator ALU, wrap-around arithmetic, no flags.
// Shared with the display stage, so it carries no state of its own.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] right,
  output logic [DW-1:0] y
);

  // Opcode decode; LIT/DROP never reach the ALU and yield zero.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = left + right;
      OP_SUB:  y = left - right;
      OP_MUL:  y = left * right;
      OP_AND:  y = left & right;
      OP_OR:   y = left | right;
      OP_XOR:  y = left ^ right;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_exec_sequencer.sv
// Command sequencer in front of the 32-entry stack/queue memory.
// Executes LIT / binary op / DROP one at a time and reports done/err.
module rpn_exec_sequencer
  import calc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rpn_exec_sequencer_if.slave  cmd,
  output logic                 mem_push,
  output logic                 mem_pop,
  output logic                 mem_stackQueue,
  output logic [DW-1:0]        mem_dataIn,
  input  logic [DW-1:0]        mem_stackOut,
  input  logic [DW-1:0]        mem_queueOut,
  input  logic                 mem_empty,
  input  logic                 mem_full
);

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [DW-1:0] result_q, result_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] top;
  logic [DW-1:0] left, right, alu_y;

  // The entry removed by a pop depends on the latched mode.
  assign top = mode_q ? mem_queueOut : mem_stackOut;

  // opA is the first pop: newer entry in stack mode, older in queue mode.
  assign left  = mode_q ? opa_q : opb_q;
  assign right = mode_q ? opb_q : opa_q;

  calc_alu #(.DW(DW)) u_alu (
    .op    (op_q),
    .left  (left),
    .right (right),
    .y     (alu_y)
  );

  assign mem_stackQueue = mode_q;
  assign cmd.cmd_ready  = (state_q == IDLE);
  assign cmd.done       = (state_q == DONE);
  assign cmd.err        = (state_q == DONE) && (err_code_q != ERR_NONE);
  assign cmd.err_code   = (state_q == DONE) ? err_code_q : ERR_NONE;
  assign cmd.result     = result_q;

  // Next-state, memory strobes and operand/result capture.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    err_code_d = err_code_q;
    result_d   = result_q;
    op_d       = op_q;
    res_d      = res_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    mem_push   = 1'b0;
    mem_pop    = 1'b0;
    mem_dataIn = '0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          op_d       = cmd.cmd_op;
          mode_d     = cmd.cmd_mode;
          err_code_d = ERR_NONE;
          if (cmd.cmd_op == OP_LIT) begin
            res_d = cmd.cmd_data;
            if (mem_full) begin
              err_code_d = ERR_OVER;
              state_d    = DONE;
            end else begin
              state_d = PUSH;
            end
          end else if (mem_empty) begin
            err_code_d = ERR_UNDER;
            state_d    = DONE;
          end else begin
            state_d = POP_A;
          end
        end
      end
      POP_A: begin
        opa_d   = top;
        mem_pop = 1'b1;
        state_d = (op_q == OP_DROP) ? DONE : POP_B;
      end
      POP_B: begin
        if (mem_empty) begin
          state_d = RESTORE;
        end else begin
          opb_d   = top;
          mem_pop = 1'b1;
          state_d = EXEC;
        end
      end
      RESTORE: begin
        // Put the lone operand back; in queue mode it lands at the tail.
        mem_push   = 1'b1;
        mem_dataIn = opa_q;
        err_code_d = ERR_UNDER;
        state_d    = DONE;
      end
      EXEC: begin
        res_d   = alu_y;
        state_d = PUSH;
      end
      PUSH: begin
        mem_push   = 1'b1;
        mem_dataIn = res_q;
        result_d   = res_q;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and externally visible registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      err_code_q <= ERR_NONE;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      err_code_q <= err_code_d;
      result_q   <= result_d;
    end
  end

  // Working registers; always written before being read in a command.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    res_q <= res_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

endmodule
